bsg_decode_issue_scoreboard: RTL

//  Issues indexed requests as one-hot dispatch strobes to num_out_p targets, allowing at most one

---
 rtl/bsg_decode_issue_scoreboard_pkg.sv | 6 +
 rtl/bsg_decode_with_v.sv | 18 +
 rtl/bsg_decode_issue_scoreboard.sv | 115 +++++++++++
 3 files changed

// File: rtl/bsg_decode_issue_scoreboard_pkg.sv
// Shared sizing defaults for the decode/issue scoreboard slice.
package bsg_decode_issue_scoreboard_pkg;

   localparam int unsigned default_num_out_lp = 128;

endpackage

// File: rtl/bsg_decode_with_v.sv
// Binary-to-one-hot decoder whose output is all-zero unless v_i is set.
module bsg_decode_with_v #(
   parameter  int unsigned num_out_p     = 4,
   localparam int unsigned lg_num_out_lp = $clog2(num_out_p)
) (
   input  logic                     v_i,
   input  logic [lg_num_out_lp-1:0] i,
   output logic [num_out_p-1:0]     o
);

   always_comb begin
      o = '0;
      for (int k = 0; k < num_out_p; k++) begin
         o[k] = v_i & (i == lg_num_out_lp'(k));
      end
   end

endmodule

// File: rtl/bsg_decode_issue_scoreboard.sv
// In-order issue of indexed requests as one-hot strobes, with at most one
// outstanding operation per target; targets release through done_i.
module bsg_decode_issue_scoreboard
   import bsg_decode_issue_scoreboard_pkg::*;
#(
   parameter  int unsigned num_out_p     = default_num_out_lp,
   localparam int unsigned lg_num_out_lp = $clog2(num_out_p),
   localparam int unsigned lg_cnt_lp     = $clog2(num_out_p + 1)
) (
   input  logic                     clk_i,
   input  logic                     reset_i,
   input  logic                     v_i,
   input  logic [lg_num_out_lp-1:0] idx_i,
   output logic                     ready_o,
   output logic                     v_o,
   output logic [num_out_p-1:0]     o,
   input  logic                     yumi_i,
   input  logic [num_out_p-1:0]     done_i,
   output logic [num_out_p-1:0]     busy_o,
   output logic [lg_cnt_lp-1:0]     count_o,
   output logic                     err_o
);

   function automatic logic [lg_cnt_lp-1:0] popcount(input logic [num_out_p-1:0] vec);
      logic [lg_cnt_lp-1:0] sum;
      sum = '0;
      for (int k = 0; k < num_out_p; k++) begin
         sum = sum + lg_cnt_lp'(vec[k]);
      end
      return sum;
   endfunction

   logic                     hold_v_q,   hold_v_d;
   logic [lg_num_out_lp-1:0] hold_idx_q, hold_idx_d;
   logic [num_out_p-1:0]     busy_q,     busy_d;
   logic [lg_cnt_lp-1:0]     count_q,    count_d;
   logic                     err_q,      err_d;

   logic hold_busy;
   logic fire;
   logic accept;
   logic in_range;

   // Busy bit of the held target, looked up from registered state only.
   always_comb begin
      hold_busy = 1'b0;
      for (int k = 0; k < num_out_p; k++) begin
         if (hold_idx_q == lg_num_out_lp'(k)) begin
            hold_busy = busy_q[k];
         end
      end
   end

   assign v_o      = hold_v_q & ~hold_busy;
   assign fire     = v_o & yumi_i;
   assign ready_o  = ~hold_v_q | fire;
   assign accept   = v_i & ready_o;
   assign in_range = 32'(idx_i) < num_out_p;

   bsg_decode_with_v #(
      .num_out_p (num_out_p)
   ) u_decode (
      .v_i (v_o),
      .i   (hold_idx_q),
      .o   (o)
   );

   // The strobe itself is the set mask once the dispatch is consumed.
   always_comb begin
      hold_v_d   = hold_v_q;
      hold_idx_d = hold_idx_q;
      err_d      = 1'b0;
      if (fire) begin
         hold_v_d = 1'b0;
      end
      if (accept) begin
         if (in_range) begin
            hold_v_d   = 1'b1;
            hold_idx_d = idx_i;
         end else begin
            err_d = 1'b1;
         end
      end
      busy_d  = (busy_q & ~done_i) | (o & {num_out_p{yumi_i}});
      count_d = count_q + lg_cnt_lp'(fire) - popcount(done_i & busy_q);
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         hold_v_q   <= 1'b0;
         hold_idx_q <= '0;
         busy_q     <= '0;
         count_q    <= '0;
         err_q      <= 1'b0;
      end else begin
         hold_v_q   <= hold_v_d;
         hold_idx_q <= hold_idx_d;
         busy_q     <= busy_d;
         count_q    <= count_d;
         err_q      <= err_d;
      end
   end

   assign busy_o  = busy_q;
   assign count_o = count_q;
   assign err_o   = err_q;

   a_yumi_needs_v : assert property (@(posedge clk_i) disable iff (reset_i)
      yumi_i |-> v_o);
   a_count_matches : assert property (@(posedge clk_i) disable iff (reset_i)
      count_q == lg_cnt_lp'($countones(busy_q)));
   a_done_on_busy : assert property (@(posedge clk_i) disable iff (reset_i)
      (done_i & ~busy_q) == '0);

endmodule
